// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box, GF(2^8) doubling, round-key selection and FSM encoding.
// Used by both the key-expansion stage and the iterative cipher.
package aes_pkg;

    localparam int NB       = 4;
    localparam int MAX_NR   = 14;
    localparam int RK_MAX_W = 32 * NB * (MAX_NR + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } cipher_state_e;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TABLE[2047 - 8 * int'(a) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Keys are left-aligned in a max-width bus so round r sits at a fixed offset for any NR.
    function automatic logic [127:0] rk_sel(input logic [RK_MAX_W-1:0] keys, input logic [3:0] r);
        logic [RK_MAX_W-1:0] shifted;
        shifted = keys << (128 * int'(r));
        return shifted[RK_MAX_W-1 -: 128];
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte i of a block is bits [127-8*i -: 8]; column c holds bytes 4c..4c+3.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] subbed;
    logic [127:0] shifted;
    logic [127:0] mixed;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        subbed  = '0;
        shifted = '0;
        mixed   = '0;
        for (int i = 0; i < 16; i++) begin
            subbed[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
        end
        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = subbed[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end
    end

    assign state_out = (last ? shifted : mixed) ^ rk;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: initial AddRoundKey on accept, then one round per clock,
// result held on a valid/ready output until taken. One block in flight.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          plaintext,
    input  logic [128*(NR+1)-1:0] round_keys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ciphertext
);

    localparam int         RK_W     = 32 * NB * (NR + 1);
    localparam logic [3:0] LAST_RND = 4'(NR);

    if ((NK != 4 && NK != 6 && NK != 8) || NR > MAX_NR) begin : g_param_check
        $error("aes_cipher_iter: unsupported NK/NR combination");
    end

    cipher_state_e       state, state_nxt;
    logic [127:0]        state_reg, state_reg_nxt;
    logic [3:0]          round_cnt, round_cnt_nxt;
    logic [RK_MAX_W-1:0] keys_al;
    logic [127:0]        rk0;
    logic [127:0]        rk_cur;
    logic [127:0]        round_out;
    logic                last;

    assign keys_al = RK_MAX_W'(round_keys) << (RK_MAX_W - RK_W);
    assign rk0     = rk_sel(keys_al, 4'd0);
    assign rk_cur  = rk_sel(keys_al, round_cnt);
    assign last    = (round_cnt == LAST_RND);

    aes_round u_round (
        .state_in  (state_reg),
        .rk        (rk_cur),
        .last      (last),
        .state_out (round_out)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            state_reg <= '0;
            round_cnt <= '0;
        end else begin
            state     <= state_nxt;
            state_reg <= state_reg_nxt;
            round_cnt <= round_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        state_reg_nxt = state_reg;
        round_cnt_nxt = round_cnt;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_reg_nxt = plaintext ^ rk0;
                    round_cnt_nxt = 4'd1;
                    state_nxt     = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_cnt > LAST_RND) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_reg_nxt = round_out;
                    round_cnt_nxt = round_cnt + 4'd1;
                    if (last) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign ciphertext = state_reg;

endmodule

// File: doc/aes_cipher_iter.md
# aes_cipher_iter

Iterative AES encryption datapath that sits directly downstream of the key-expansion stage. It consumes that stage's flattened round-key bus and one 128-bit plaintext block per transaction. It applies the initial AddRoundKey plus NR rounds, one round per clock. It returns the ciphertext through a valid/ready output handshake, and accepts a new block only after the previous result is taken.

## Interface
- `NK`, default 4: key length in 32-bit words (4/6/8). Informational; must match the key-expansion stage.
- `NR`, default 10: number of rounds (10/12/14).
- `clk` input, 1: sole clock; all state updates on rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: plaintext offered.
- `in_ready` output, 1: core idle and able to accept.
- `plaintext` input, 128: block to encrypt; byte 0 = [127:120], FIPS-197 column-major.
- `round_keys` input, 128*(NR+1): expanded key schedule; word w0 at the MSBs, round r key = bits [128*(NR+1)-1-128*r -: 128].
- `out_valid` output, 1: ciphertext available.
- `out_ready` input, 1: downstream accepts ciphertext.
- `ciphertext` output, 128: result, same byte order as `plaintext`.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: `state_reg` <= `plaintext` ^ rk0, `round_cnt` <= 1, go to ROUND.
- ROUND (`in_ready`=0) applies one round per cycle:
  - Rounds 1..NR-1: `state_reg` <= AddRoundKey(MixColumns(ShiftRows(SubBytes(`state_reg`))), rk[`round_cnt`]).
  - Round NR omits MixColumns.
  - `round_cnt` increments. After round NR completes, go to DONE.
- DONE:
  - `out_valid`=1 and `ciphertext`=`state_reg`, both held stable until `out_ready`.
  - On `out_valid`&&`out_ready`, go to IDLE.
- No pipelining: exactly one block in flight.
- `round_keys` is not captured. It must stay stable from the accept edge until `out_valid` rises; changing it mid-operation corrupts only the current block.
- `round_cnt` width is 4 bits (NR ≤ 14). A value above NR is unreachable; if it is ever observed, return to IDLE.
- MixColumns uses GF(2^8) with reduction polynomial 0x11b: xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 0).
- Reset:
  - Clears `state_reg` to 0 and `round_cnt` to 0, and sets state to IDLE.
  - After reset: `in_ready`=1, `out_valid`=0, `ciphertext`=0.
  - Reset in ROUND or DONE abandons the block; no output is produced for it.
- `in_valid` while busy is ignored (not accepted, no error). The upstream must hold the block.

## Timing
- Accept at edge E.
- `out_valid` rises after edge E+NR: 10 cycles for AES-128, 14 for AES-256.
- If `out_ready` is already high, the handshake completes at edge E+NR+1. `in_ready` is high in the following cycle.
- Minimum accept-to-accept spacing: NR+2 cycles.
- `out_ready` held low: `out_valid` and `ciphertext` stay constant indefinitely.
- `out_ready` high while `out_valid`=0 has no effect.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `aes_pkg` contains:
  - `sbox` function (256-entry table, shared with key expansion).
  - `xtime`.
  - Constant NB=4.
  - Round-key slice helper `rk_sel(round_keys, r)`.
- Sub-module `aes_round`: combinational single round, with inputs `state_in`, `rk`, `last` (skip MixColumns) and output `state_out`. Instantiated once. Its ShiftRows/MixColumns byte mapping is unit-testable in isolation.

## Test plan
- AES-128 FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c (schedule from key-expansion stage), plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fb dc118597196a0b32, with `out_valid` exactly 10 cycles after accept.
- AES-128 App. C.1:
  - Stimulus: key 000102…0f, plaintext 00112233445566778899aabbccddeeff.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-256 C.3 (NK=8, NR=14):
  - Stimulus: key 000102…1f, same plaintext as C.1.
  - Required: ciphertext 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid` rises.
  - Required: ciphertext stable, `in_ready`=0. Release gives a single handshake, then `in_ready`=1 next cycle.
- Busy input and back-to-back:
  - Stimulus: `in_valid` toggled with changing plaintext during ROUND.
  - Required: ignored; a second block offered immediately after the handshake is accepted and correct.
- Reset mid-round:
  - Stimulus: assert `rst` at round 5.
  - Required: next cycle `in_ready`=1, `out_valid`=0, `ciphertext`=0; no stray `out_valid`. A new block afterwards encrypts correctly.
